// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream_arb round-robin output scheduler.
// Optional header beat support is enabled by defining STREAM_ARB_HDR_EN.
package stream_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Header beat data: group id placed at this bit offset, rest zero.
    localparam int unsigned HDR_ID_LSB = 0;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_arb_if.sv
// Handshake bundle between the core array, the result mux and the output DMA.
// rd_hdr exists only when STREAM_ARB_HDR_EN is defined.
interface stream_arb_if
    import stream_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 16,
    parameter int unsigned WORDS = 8
);
    localparam int unsigned IW = idx_w(NREQ);
    localparam int unsigned WW = idx_w(WORDS);

    logic [NREQ-1:0] req_done;
    logic            dst_ready;
    logic            dst_valid;
    logic            dst_last;
    logic            rd_en;
    logic [IW-1:0]   rd_sel;
    logic [WW-1:0]   rd_idx;
    logic            busy;
    logic            err_overrun;
`ifdef STREAM_ARB_HDR_EN
    logic            rd_hdr;
`endif

    modport slave (
        input  req_done,
        input  dst_ready,
        output dst_valid,
        output dst_last,
        output rd_en,
        output rd_sel,
        output rd_idx,
        output busy,
        output err_overrun
`ifdef STREAM_ARB_HDR_EN
        ,
        output rd_hdr
`endif
    );

    modport master (
        output req_done,
        output dst_ready,
        input  dst_valid,
        input  dst_last,
        input  rd_en,
        input  rd_sel,
        input  rd_idx,
        input  busy,
        input  err_overrun
`ifdef STREAM_ARB_HDR_EN
        ,
        input  rd_hdr
`endif
    );

endinterface

// File: rtl/stream_arb_rr_pick.sv
// Cyclic priority encoder: first set bit of pending at or after ptr, wrapping.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 16,
    localparam int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   grant
);

    int unsigned j;

    always_comb begin
        any   = 1'b0;
        grant = '0;
        j     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr) + i) % NREQ;
            if (!any && pending[IW'(j)]) begin
                any   = 1'b1;
                grant = IW'(j);
            end
        end
    end

endmodule

// File: rtl/stream_arb.sv
// Round-robin scheduler sharing one AXI-Stream result output among NREQ groups.
// Define STREAM_ARB_HDR_EN to prefix each burst with a header beat (rd_hdr).
module stream_arb
    import stream_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 16,
    parameter int unsigned WORDS = 8
) (
    input  logic         clk,
    input  logic         rst,
    stream_arb_if.slave  io
);

    localparam int unsigned   IW       = idx_w(NREQ);
    localparam int unsigned   WW       = idx_w(WORDS);
    localparam logic [WW-1:0] LAST_IDX = WW'(WORDS - 1);
    localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [NREQ-1:0] held;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [WW-1:0]   idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            err_q, err_d;
    logic            any;
    logic [IW-1:0]   grant;
    logic            rd_en;
`ifdef STREAM_ARB_HDR_EN
    logic            hdr_q, hdr_d;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .pending (pending_q),
        .ptr     (ptr_q),
        .any     (any),
        .grant   (grant)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        held    = pending_q;
        rd_en   = 1'b0;
`ifdef STREAM_ARB_HDR_EN
        hdr_d   = hdr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    held[grant] = 1'b0;
                    sel_d       = grant;
                    ptr_d       = (grant == LAST_REQ) ? '0 : grant + 1'b1;
                    idx_d       = '0;
                    state_d     = SEND;
`ifdef STREAM_ARB_HDR_EN
                    hdr_d       = 1'b1;
`endif
                end
            end
            SEND: begin
                rd_en = ~valid_q | io.dst_ready;
`ifdef STREAM_ARB_HDR_EN
                if (rd_en && hdr_q) begin
                    hdr_d = 1'b0;
                end else
`endif
                if (rd_en) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase

        // A pulse on the group being granted re-queues it rather than overrunning.
        pending_d = held | io.req_done;
        err_d     = err_q | (|(held & io.req_done));

        if (rd_en) begin
            valid_d = 1'b1;
        end else if (io.dst_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        last_d = rd_en ? (idx_q == LAST_IDX) : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef STREAM_ARB_HDR_EN
            hdr_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_q     <= err_d;
`ifdef STREAM_ARB_HDR_EN
            hdr_q     <= hdr_d;
`endif
        end
    end

    assign io.rd_en       = rd_en;
    assign io.rd_sel      = sel_q;
    assign io.rd_idx      = idx_q;
    assign io.dst_valid   = valid_q;
    assign io.dst_last    = last_q;
    assign io.busy        = (state_q != IDLE) | valid_q;
    assign io.err_overrun = err_q;
`ifdef STREAM_ARB_HDR_EN
    assign io.rd_hdr      = rd_en & hdr_q;
`endif

endmodule

// File: tb/tb_stream_arb.sv
// Directed bench for stream_arb: one cycle-accurate vector table plus burst-level
// sequences for ordering, backpressure, re-queue/overrun, reset and header beats.
module tb_stream_arb;
    import stream_arb_pkg::*;

    localparam int unsigned NREQ  = 16;
    localparam int unsigned WORDS = 8;
`ifdef STREAM_ARB_HDR_EN
    localparam int unsigned HB = 1;
`else
    localparam int unsigned HB = 0;
`endif
    localparam int unsigned BL = WORDS + HB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_arb_if #(.NREQ(NREQ), .WORDS(WORDS)) io ();

    stream_arb #(.NREQ(NREQ), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    // Datapath output register: tag = {hdr, sel, idx}
    logic [7:0] dp_q;
    always @(posedge clk) begin
        if (rst) dp_q <= '0;
`ifdef STREAM_ARB_HDR_EN
        else if (io.rd_en) dp_q <= {io.rd_hdr, io.rd_sel, io.rd_idx};
`else
        else if (io.rd_en) dp_q <= {1'b0, io.rd_sel, io.rd_idx};
`endif
    end

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    logic       s_en, s_vld, s_lst, s_bsy, s_err, s_hdr;
    logic [3:0] s_sel;
    logic [2:0] s_idx;
    logic [7:0] s_dp;

    logic [7:0] en_log[$];
    int         en_cyc[$];
    logic [8:0] beat_log[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic             rst;
        logic [NREQ-1:0]  req;
        logic             rdy;
        logic [11:0]      exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] obs();
        return {s_en, s_sel, s_idx, s_vld, s_lst, s_bsy, s_err};
    endfunction

    task automatic step(input logic r, input logic [NREQ-1:0] req, input logic rdy);
        @(negedge clk);
        rst          = r;
        io.req_done  = req;
        io.dst_ready = rdy;
        #1;
        s_en  = io.rd_en;
        s_sel = io.rd_sel;
        s_idx = io.rd_idx;
        s_vld = io.dst_valid;
        s_lst = io.dst_last;
        s_bsy = io.busy;
        s_err = io.err_overrun;
        s_dp  = dp_q;
`ifdef STREAM_ARB_HDR_EN
        s_hdr = io.rd_hdr;
`else
        s_hdr = 1'b0;
`endif
        if (s_en === 1'b1) begin
            en_log.push_back({s_hdr, s_sel, s_idx});
            en_cyc.push_back(cyc);
        end
        if (s_vld === 1'b1 && rdy) beat_log.push_back({s_lst, s_dp});
        cyc++;
        @(posedge clk);
    endtask

    task automatic clear_logs();
        en_log.delete();
        en_cyc.delete();
        beat_log.delete();
        exp_q.delete();
        cyc = 0;
    endtask

    task automatic do_reset();
        step(1'b1, '0, 1'b1);
        step(1'b1, '0, 1'b1);
        clear_logs();
    endtask

    task automatic idle_run(input int n);
        repeat (n) step(1'b0, '0, 1'b1);
    endtask

    task automatic push_burst(input logic [3:0] sel);
        if (HB != 0) exp_q.push_back({1'b1, sel, 3'd0});
        for (int i = 0; i < int'(WORDS); i++) exp_q.push_back({1'b0, sel, 3'(i)});
    endtask

    task automatic cmp_log(input string name);
        chk({name, " rd_en count"}, 64'(en_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < en_log.size(); i++)
            chk($sformatf("%s rd_en[%0d]", name, i), en_log[i], exp_q[i]);
    endtask

    task automatic cmp_beats(input string name);
        chk({name, " beat count"}, 64'(beat_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < beat_log.size(); i++)
            chk($sformatf("%s beat[%0d]", name, i), beat_log[i],
                {(i == exp_q.size() - 1) ? 1'b1 : 1'b0, exp_q[i]});
    endtask

    task automatic add(input logic [NREQ-1:0] req, input logic en, input logic [3:0] sel,
                       input logic [2:0] idx, input logic v, input logic l,
                       input logic b, input logic e);
        vec_t t;
        t.rst = 1'b0;
        t.req = req;
        t.rdy = 1'b1;
        t.exp = {en, sel, idx, v, l, b, e};
        tbl.push_back(t);
    endtask

    initial begin
        io.req_done  = '0;
        io.dst_ready = 1'b1;

        // Single burst to group 0, cycle by cycle
        add('0,           0, 0, 0, 0, 0, 0, 0);
        add(16'h0001,     0, 0, 0, 0, 0, 0, 0);
        add('0,           0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < int'(BL); k++)
            add('0, 1, 0, (k < int'(HB)) ? 3'd0 : 3'(k - int'(HB)), (k > 0), 0, 1, 0);
        add('0,           0, 0, 0, 1, 1, 1, 0);
        add('0,           0, 0, 0, 0, 1, 0, 0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rdy);
            chk($sformatf("tbl[%0d]", i), obs(), tbl[i].exp);
        end

        // Simultaneous pulses 3,1,9 from pointer 0, then 9,10 from pointer 10
        do_reset();
        step(1'b0, 16'h020A, 1'b1);
        idle_run(3 * (BL + 1) + 4);
        push_burst(4'd1); push_burst(4'd3); push_burst(4'd9);
        cmp_log("rr");
        if (en_cyc.size() > BL) chk("rr gap", 64'(en_cyc[BL] - en_cyc[BL-1]), 64'd2);
        else chk("rr gap present", 64'(en_cyc.size()), 64'(BL + 1));
        clear_logs();
        step(1'b0, 16'h0600, 1'b1);
        idle_run(2 * (BL + 1) + 4);
        push_burst(4'd10); push_burst(4'd9);
        cmp_log("ptr");

        // Backpressure: ready low for 5 cycles while data word 3 is on the output
        do_reset();
        step(1'b0, 16'h0010, 1'b1);
        for (int c = 1; c < 30; c++) begin
            if (c >= 6 + int'(HB) && c <= 10 + int'(HB)) begin
                step(1'b0, '0, 1'b0);
                chk($sformatf("stall c%0d", c), {s_en, s_vld, s_lst, s_dp},
                    {1'b0, 1'b1, 1'b0, 8'h23});
            end else begin
                step(1'b0, '0, 1'b1);
            end
        end
        push_burst(4'd4);
        cmp_beats("bp");

        // Re-queue during own burst; double pulse to a pending group overruns
        do_reset();
        for (int c = 0; c < 40; c++) begin
            case (c)
                0, 4:    step(1'b0, 16'h0004, 1'b1);
                6, 7:    step(1'b0, 16'h0020, 1'b1);
                default: step(1'b0, '0, 1'b1);
            endcase
            if (c == 7) chk("err before overrun", 64'(s_err), 64'd0);
        end
        chk("err sticky", 64'(s_err), 64'd1);
        push_burst(4'd2); push_burst(4'd5); push_burst(4'd2);
        cmp_log("requeue");

        // Reset mid-burst with groups 7 and 11 still pending
        do_reset();
        step(1'b0, 16'h0881, 1'b1);
        idle_run(6);
        chk("pre-rst valid", 64'(s_vld), 64'd1);
        step(1'b1, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("post-rst outputs", 64'(obs()), 64'd0);
        clear_logs();
        idle_run(30);
        chk("post-rst no rd_en", 64'(en_log.size()), 64'd0);
        chk("post-rst busy", 64'(s_bsy), 64'd0);

`ifdef STREAM_ARB_HDR_EN
        // Header beat ahead of group 6 data
        do_reset();
        step(1'b0, 16'h0040, 1'b1);
        idle_run(BL + 6);
        push_burst(4'd6);
        cmp_log("hdr");
        cmp_beats("hdr");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
